// File: rtl/gap_stream_controller.sv
// Global average pooling stream controller: accumulates N pixels per channel and emits the channel average.
// Optional GAP_ROUND_EN: round to nearest (ties away from zero) instead of truncating toward zero.
module gap_stream_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 160,
  parameter int HEIGHT     = 7,
  parameter int WIDTH      = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(CHANNELS)-1:0]   out_channel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done
);

  localparam int N         = HEIGHT * WIDTH;
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(N);
  localparam int CH_W      = $clog2(CHANNELS);
  localparam int PIX_W     = $clog2(N + 1);
  localparam int CNT_W     = $clog2(ACC_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, OUTPUT} state_t;

  state_t                 state, state_next;
  logic [ACC_WIDTH-1:0]   acc;
  logic [PIX_W-1:0]       pix_cnt;
  logic [CH_W-1:0]        chan;
  logic [CNT_W-1:0]       div_cnt;
  logic [ACC_WIDTH-1:0]   quot;
  logic [ACC_WIDTH:0]     rem;
  logic                   neg;
  logic [DATA_WIDTH-1:0]  out_data_r;
  logic                   done_r;

  logic                   in_beat, last_beat, last_chan, div_last;
  logic [ACC_WIDTH-1:0]   acc_sum, sum_abs, dividend, quot_signed;
  logic [ACC_WIDTH:0]     rem_sh, rem_nx;
  logic                   q_bit;

  assign in_beat   = in_valid && (state == ACCUM);
  assign last_beat = in_beat && (pix_cnt == PIX_W'(N - 1));
  assign last_chan = (chan == CH_W'(CHANNELS - 1));
  assign div_last  = (div_cnt == CNT_W'(ACC_WIDTH));

  assign acc_sum = acc + {{(ACC_WIDTH - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign sum_abs = acc_sum[ACC_WIDTH-1] ? (~acc_sum + 1'b1) : acc_sum;

`ifdef GAP_ROUND_EN
  assign dividend = sum_abs + ACC_WIDTH'(N / 2);
`else
  assign dividend = sum_abs;
`endif

  // One restoring-division step: shift in the next dividend bit, subtract N when it fits.
  always_comb begin
    rem_sh = {rem[ACC_WIDTH-1:0], quot[ACC_WIDTH-1]};
    rem_nx = rem_sh;
    q_bit  = 1'b0;
    if (rem_sh >= (ACC_WIDTH + 1)'(N)) begin
      rem_nx = rem_sh - (ACC_WIDTH + 1)'(N);
      q_bit  = 1'b1;
    end
  end

  assign quot_signed = neg ? (~quot + 1'b1) : quot;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (last_beat) state_next = DIVIDE;
      end
      DIVIDE: begin
        if (div_last) state_next = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = last_chan ? IDLE : ACCUM;
      end
      default: state_next = IDLE;
    endcase
  end

  // Divider is seeded on the Nth beat so ACC_WIDTH step cycles plus one finalize cycle follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      pix_cnt    <= '0;
      chan       <= '0;
      div_cnt    <= '0;
      quot       <= '0;
      rem        <= '0;
      neg        <= 1'b0;
      out_data_r <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            pix_cnt <= '0;
            chan    <= '0;
          end
        end
        ACCUM: begin
          if (in_beat) begin
            acc <= acc_sum;
            if (last_beat) begin
              pix_cnt <= '0;
              div_cnt <= '0;
              quot    <= dividend;
              rem     <= '0;
              neg     <= acc_sum[ACC_WIDTH-1];
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
        end
        DIVIDE: begin
          if (div_last) begin
            out_data_r <= quot_signed[DATA_WIDTH-1:0];
          end else begin
            rem     <= rem_nx;
            quot    <= {quot[ACC_WIDTH-2:0], q_bit};
            div_cnt <= div_cnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (last_chan) begin
              done_r <= 1'b1;
            end else begin
              chan <= chan + 1'b1;
              acc  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data    = out_data_r;
  assign out_channel = chan;
  assign done        = done_r;

endmodule

// File: tb/tb_gap_stream_controller.sv
// Directed self-checking bench for gap_stream_controller at default parameters (N=49, 160 channels).
module tb_gap_stream_controller;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [15:0] in_data;
  logic        busy, in_ready, out_valid, done;
  logic [15:0] out_data;
  logic [7:0]  out_channel;

  int vectors     = 0;
  int miscompares = 0;
  logic signed [15:0] pix [49];

  gap_stream_controller dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_channel(out_channel),
    .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_out_data"}, $signed(out_data), 0);
    chk({tag, "_out_channel"}, {24'd0, out_channel}, 0);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 49; i++) pix[i] = 16'(v);
  endtask

  // Feed pix[0..n-1]; optionally pulse start alongside beat pulse_at.
  task automatic feed(input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      in_data  = pix[i];
      in_valid = 1'b1;
      start    = (i == pulse_at);
      while (!in_ready && waited < 100) begin
        tick();
        waited++;
      end
      if (waited == 100) begin
        chk("in_ready_wait", 0, 1);
        break;
      end
      tick();
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_val, input int exp_ch);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!out_valid && k < 100);
    chk({tag, "_latency"}, k, 23);
    chk({tag, "_out_data"}, $signed(out_data), exp_val);
    chk({tag, "_out_channel"}, {24'd0, out_channel}, exp_ch);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) tick();
    reset_chk("rst_init");

    start = 1'b1;
    tick();
    chk("rst_over_start_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_in_ready", {31'd0, in_ready}, 1);

    fill(3);
    feed(49, -1);
    wait_out("ch0_all3", 3, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_out_valid", {31'd0, out_valid}, 1);
      chk("hold_out_data", $signed(out_data), 3);
      chk("hold_out_channel", {24'd0, out_channel}, 0);
      chk("hold_in_ready", {31'd0, in_ready}, 0);
    end
    accept();
    chk("post_accept_out_valid", {31'd0, out_valid}, 0);
    chk("post_accept_in_ready", {31'd0, in_ready}, 1);
    chk("post_accept_channel", {24'd0, out_channel}, 1);
    chk("post_accept_done", {31'd0, done}, 0);

    fill(1); pix[17] = 16'sd0;
    feed(49, -1);
`ifdef GAP_ROUND_EN
    wait_out("ch1_sum48", 1, 1);
`else
    wait_out("ch1_sum48", 0, 1);
`endif
    accept();

    fill(0); pix[0] = -16'sd25;
    feed(49, -1);
`ifdef GAP_ROUND_EN
    wait_out("ch2_sum_m25", -1, 2);
`else
    wait_out("ch2_sum_m25", 0, 2);
`endif
    accept();

    fill(-32768);
    feed(49, -1);
    wait_out("ch3_min", -32768, 3);
    accept();

    fill(-5); pix[30] = -16'sd30;
    feed(49, -1);
`ifdef GAP_ROUND_EN
    wait_out("ch4_sum_m270", -6, 4);
`else
    wait_out("ch4_sum_m270", -5, 4);
`endif
    accept();

    for (int i = 0; i < 49; i++) pix[i] = 16'(i * i);
    feed(49, -1);
    wait_out("ch5_squares", 776, 5);
    accept();

    fill(7);
    feed(49, -1);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_chk("rst_divide");

    start = 1'b1; tick(); start = 1'b0;
    fill(9);
    feed(20, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_chk("rst_accum");
    start = 1'b1; tick(); start = 1'b0;
    fill(2);
    feed(49, -1);
    wait_out("after_rst", 2, 0);
    accept();

    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 160; c++) begin
      fill(c - 80);
      feed(49, (c == 50) ? 10 : -1);
      wait_out("frame", c - 80, c);
      tick();
      chk("frame_done", {31'd0, done}, (c == 159) ? 1 : 0);
      chk("frame_busy", {31'd0, busy}, (c == 159) ? 0 : 1);
      chk("frame_no_bubble", {31'd0, out_valid}, 0);
    end
    tick();
    chk("done_one_cycle", {31'd0, done}, 0);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
